// File: rtl/prefetch_issue_queue_if.sv
// Prefetch request / MSHR issue handshake bundle for prefetch_issue_queue.
// slave = the queue, master = prefetcher plus MSHR arbiter side.
interface prefetch_issue_queue_if;
  logic        io_pf_valid;
  logic        io_pf_ready;
  logic [39:0] io_pf_bits_addr;
  logic [4:0]  io_pf_bits_uop_mem_cmd;
  logic        io_demand_busy;
  logic        io_flush;
  logic        io_mshr_req_valid;
  logic        io_mshr_req_ready;
  logic [39:0] io_mshr_req_bits_addr;
  logic [4:0]  io_mshr_req_bits_cmd;
  logic [15:0] io_drop_count;

  modport slave (
    input  io_pf_valid, io_pf_bits_addr, io_pf_bits_uop_mem_cmd,
    input  io_demand_busy, io_flush, io_mshr_req_ready,
    output io_pf_ready, io_mshr_req_valid, io_mshr_req_bits_addr,
    output io_mshr_req_bits_cmd, io_drop_count
  );

  modport master (
    output io_pf_valid, io_pf_bits_addr, io_pf_bits_uop_mem_cmd,
    output io_demand_busy, io_flush, io_mshr_req_ready,
    input  io_pf_ready, io_mshr_req_valid, io_mshr_req_bits_addr,
    input  io_mshr_req_bits_cmd, io_drop_count
  );
endinterface

// File: rtl/prefetch_issue_queue.sv
// Next-line prefetch issue queue: dedups block requests against queued and
// recently issued blocks, buffers them, and issues to the MSHRs behind demand.
module prefetch_issue_queue #(
  parameter int unsigned ENTRIES        = 4,
  parameter int unsigned FILTER_ENTRIES = 8
) (
  input logic clock,
  input logic reset,
  prefetch_issue_queue_if.slave io
);
  localparam int unsigned PW = $clog2(ENTRIES);
  localparam int unsigned FW = $clog2(FILTER_ENTRIES);
  localparam logic [PW:0]  FULL_CNT = (PW+1)'(ENTRIES);
  localparam logic [PW:0]  CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [FW-1:0] FPTR_ONE = FW'(1);

  logic [33:0]   blk_q [ENTRIES];
  logic [33:0]   blk_d [ENTRIES];
  logic [4:0]    cmd_q [ENTRIES];
  logic [4:0]    cmd_d [ENTRIES];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [FILTER_ENTRIES-1:0] flt_valid_q, flt_valid_d;
  logic [33:0]   flt_blk_q [FILTER_ENTRIES];
  logic [33:0]   flt_blk_d [FILTER_ENTRIES];
  logic [FW-1:0] flt_ptr_q, flt_ptr_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          full, empty;
  logic [33:0]   pf_blk;
  logic          cmd_ok, fifo_hit, flt_hit;
  logic          accept, drop, enq, issue;
  logic [PW-1:0] off;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^io.io_pf_bits_addr[5:0];

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign pf_blk = io.io_pf_bits_addr[39:6];
  assign cmd_ok = (io.io_pf_bits_uop_mem_cmd[4:1] == 4'h1);

  assign io.io_pf_ready           = ~full & ~io.io_flush;
  assign io.io_mshr_req_valid     = ~empty & ~io.io_demand_busy & ~io.io_flush;
  assign io.io_mshr_req_bits_addr = {blk_q[head_q], 6'h0};
  assign io.io_mshr_req_bits_cmd  = cmd_q[head_q];
  assign io.io_drop_count         = drop_cnt_q;

  assign accept = io.io_pf_valid & io.io_pf_ready;
  assign issue  = io.io_mshr_req_valid & io.io_mshr_req_ready;
  assign drop   = ~cmd_ok | fifo_hit | flt_hit;
  assign enq    = accept & ~drop;

  // Compare against every live FIFO slot (head included, even if it pops this
  // cycle) and every valid filter slot, both taken from current state.
  always_comb begin
    fifo_hit = 1'b0;
    flt_hit  = 1'b0;
    off      = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (blk_q[i] == pf_blk)) fifo_hit = 1'b1;
    end
    for (int unsigned i = 0; i < FILTER_ENTRIES; i++) begin
      if (flt_valid_q[i] && (flt_blk_q[i] == pf_blk)) flt_hit = 1'b1;
    end
  end

  always_comb begin
    blk_d       = blk_q;
    cmd_d       = cmd_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    flt_valid_d = flt_valid_q;
    flt_blk_d   = flt_blk_q;
    flt_ptr_d   = flt_ptr_q;
    drop_cnt_d  = drop_cnt_q;

    if (accept && drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;

    if (io.io_flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      flt_valid_d = '0;
      flt_ptr_d   = '0;
    end else begin
      if (enq) begin
        blk_d[tail_q] = pf_blk;
        cmd_d[tail_q] = io.io_pf_bits_uop_mem_cmd;
        tail_d        = tail_q + PTR_ONE;
      end
      if (issue) begin
        head_d                 = head_q + PTR_ONE;
        flt_blk_d[flt_ptr_q]   = blk_q[head_q];
        flt_valid_d[flt_ptr_q] = 1'b1;
        flt_ptr_d              = flt_ptr_q + FPTR_ONE;
      end
      case ({enq, issue})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        blk_q[i] <= '0;
        cmd_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FILTER_ENTRIES; i++) flt_blk_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flt_valid_q <= '0;
      flt_ptr_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      blk_q       <= blk_d;
      cmd_q       <= cmd_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flt_valid_q <= flt_valid_d;
      flt_blk_q   <= flt_blk_d;
      flt_ptr_q   <= flt_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Scoreboard bench for prefetch_issue_queue: a queue/filter model predicts
// every cycle's handshakes, issued address/cmd and drop count.
module tb_prefetch_issue_queue;
  localparam int unsigned ENTRIES = 4;
  localparam int unsigned FILTER_ENTRIES = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  prefetch_issue_queue_if io ();

  prefetch_issue_queue #(.ENTRIES(ENTRIES), .FILTER_ENTRIES(FILTER_ENTRIES)) dut (
    .clock(clock),
    .reset(reset),
    .io   (io.slave)
  );

  typedef struct {
    logic [33:0] blk;
    logic [4:0]  cmd;
  } sb_t;

  sb_t         sb[$];
  logic [33:0] f_blk [FILTER_ENTRIES];
  bit          f_v   [FILTER_ENTRIES];
  int          f_ptr;
  int          m_drop;
  int          checks;
  int          failures;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model(input bit clr_drop);
    sb.delete();
    for (int i = 0; i < FILTER_ENTRIES; i++) f_v[i] = 1'b0;
    f_ptr = 0;
    if (clr_drop) m_drop = 0;
  endtask

  // Predict the coming edge from the model and compare the DUT's outputs.
  always @(negedge clock) begin
    bit   exp_ready, exp_valid, acc, iss, dup;
    logic [33:0] b;
    if (reset) begin
      clear_model(1'b1);
    end else begin
      exp_ready = (sb.size() < ENTRIES) && !io.io_flush;
      exp_valid = (sb.size() > 0) && !io.io_demand_busy && !io.io_flush;
      check_eq("pf_ready", 64'(io.io_pf_ready), 64'(exp_ready));
      check_eq("mshr_valid", 64'(io.io_mshr_req_valid), 64'(exp_valid));
      if (exp_valid) begin
        check_eq("mshr_addr", 64'(io.io_mshr_req_bits_addr), 64'({sb[0].blk, 6'h0}));
        check_eq("mshr_cmd", 64'(io.io_mshr_req_bits_cmd), 64'(sb[0].cmd));
      end
      check_eq("drop_count", 64'(io.io_drop_count), 64'(m_drop));
      acc = io.io_pf_valid && exp_ready;
      iss = exp_valid && io.io_mshr_req_ready;
      b   = io.io_pf_bits_addr[39:6];
      dup = 1'b0;
      if (acc) begin
        if (io.io_pf_bits_uop_mem_cmd[4:1] != 4'h1) dup = 1'b1;
        foreach (sb[i]) if (sb[i].blk == b) dup = 1'b1;
        for (int i = 0; i < FILTER_ENTRIES; i++) if (f_v[i] && f_blk[i] == b) dup = 1'b1;
        if (dup && m_drop < 65535) m_drop++;
      end
      if (io.io_flush) begin
        clear_model(1'b0);
      end else begin
        if (iss) begin
          f_blk[f_ptr] = sb[0].blk;
          f_v[f_ptr]   = 1'b1;
          f_ptr        = (f_ptr + 1) % FILTER_ENTRIES;
          void'(sb.pop_front());
        end
        if (acc && !dup) sb.push_back('{blk: b, cmd: io.io_pf_bits_uop_mem_cmd});
      end
    end
  end

  task automatic push(input logic [39:0] a, input logic [4:0] c);
    bit fired;
    fired = 1'b0;
    io.io_pf_valid            = 1'b1;
    io.io_pf_bits_addr        = a;
    io.io_pf_bits_uop_mem_cmd = c;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clock);
      fired = io.io_pf_ready;
      @(posedge clock);
      #1;
    end
    if (!fired) check_eq("push_timeout", 64'(0), 64'(1));
    io.io_pf_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    check_eq("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pf_ready"}, 64'(io.io_pf_ready), 64'(1));
    check_eq({tag, "_mshr_valid"}, 64'(io.io_mshr_req_valid), 64'(0));
    check_eq({tag, "_addr"}, 64'(io.io_mshr_req_bits_addr), 64'(0));
    check_eq({tag, "_cmd"}, 64'(io.io_mshr_req_bits_cmd), 64'(0));
    check_eq({tag, "_drop"}, 64'(io.io_drop_count), 64'(0));
  endtask

  logic [15:0] d0;

  initial begin
    checks   = 0;
    failures = 0;
    clear_model(1'b1);
    io.io_pf_valid = 1'b0;
    io.io_pf_bits_addr = '0;
    io.io_pf_bits_uop_mem_cmd = '0;
    io.io_demand_busy = 1'b0;
    io.io_flush = 1'b0;
    io.io_mshr_req_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    // single request issues the cycle after acceptance
    push(40'h80001000, 5'h2);
    check_eq("first_issue_valid", 64'(io.io_mshr_req_valid), 64'(1));
    check_eq("first_issue_addr", 64'(io.io_mshr_req_bits_addr), 64'h80001000);
    drain();

    io.io_flush = 1'b1;
    @(posedge clock); #1 io.io_flush = 1'b0;

    // same-block duplicate while queued
    io.io_mshr_req_ready = 1'b0;
    push(40'h80001010, 5'h2);
    push(40'h80001038, 5'h3);
    check_eq("dup_drop_count", 64'(io.io_drop_count), 64'(1));
    io.io_mshr_req_ready = 1'b1;
    drain();

    // fill to full, stall the 5th, one issue frees a slot, wrap order
    io.io_flush = 1'b1;
    @(posedge clock); #1 io.io_flush = 1'b0;
    io.io_mshr_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(40'h90000000 + 40'(k * 64), 5'h2 + 5'(k % 2));
    check_eq("full_ready", 64'(io.io_pf_ready), 64'(0));
    fork
      push(40'h90000100, 5'h3);
      begin
        repeat (3) @(posedge clock);
        #1 io.io_mshr_req_ready = 1'b1;
        @(posedge clock);
        #1 io.io_mshr_req_ready = 1'b0;
      end
    join
    io.io_mshr_req_ready = 1'b1;
    drain();

    // recently-issued filter and its round-robin eviction
    push(40'h80002000, 5'h2);
    drain();
    d0 = io.io_drop_count;
    push(40'h80002000, 5'h2);
    check_eq("filter_drop", 64'(io.io_drop_count - d0), 64'(1));
    drain();
    for (int k = 0; k < 8; k++) begin
      push(40'h80003000 + 40'(k * 64), 5'h3);
      drain();
    end
    d0 = io.io_drop_count;
    push(40'h80002000, 5'h2);
    check_eq("evicted_accept", 64'(io.io_drop_count - d0), 64'(0));
    drain();

    // demand miss holds off issue
    io.io_mshr_req_ready = 1'b0;
    push(40'hA0000000, 5'h3);
    io.io_demand_busy = 1'b1;
    io.io_mshr_req_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      check_eq("busy_hold", 64'(io.io_mshr_req_valid), 64'(0));
    end
    io.io_demand_busy = 1'b0;
    drain();

    // flush with entries queued, then async reset mid-queue
    io.io_mshr_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(40'hB0000000 + 40'(k * 64), 5'h2);
    io.io_flush = 1'b1;
    @(negedge clock);
    check_eq("flush_ready", 64'(io.io_pf_ready), 64'(0));
    @(posedge clock); #1 io.io_flush = 1'b0;
    check_eq("flush_empty", 64'(io.io_mshr_req_valid), 64'(0));
    check_eq("flush_keep_drop", 64'(io.io_drop_count), 64'(m_drop));
    d0 = io.io_drop_count;
    push(40'hC0000000, 5'h0);
    check_eq("bad_cmd_drop", 64'(io.io_drop_count - d0), 64'(1));
    d0 = io.io_drop_count;
    push(40'h80002000, 5'h2);
    check_eq("flush_filter_clear", 64'(io.io_drop_count - d0), 64'(0));
    push(40'hC0000040, 5'h3);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prefetch_issue_queue.md
# prefetch_issue_queue

Consumer side of the next-line prefetch interface in the L1 data cache. Accepts block-prefetch requests from the prefetcher on a valid/ready handshake, discards duplicates of blocks already queued or recently issued, buffers survivors in a small FIFO, and issues them to the MSHR file only when no demand miss is competing. Sits between the prefetcher and the MSHR allocation arbiter.

## Interface
- ENTRIES, 4, FIFO depth (power of two, ≥2)
- FILTER_ENTRIES, 8, recently-issued block filter size (power of two, ≥2)
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- io_pf_valid  in  1  prefetch request valid
- io_pf_ready  out  1  queue can accept this cycle
- io_pf_bits_addr  in  40  request byte address
- io_pf_bits_uop_mem_cmd  in  5  5'h2 prefetch-read, 5'h3 prefetch-write
- io_demand_busy  in  1  demand miss requesting MSHR this cycle (priority)
- io_flush  in  1  drop all queued and filtered state
- io_mshr_req_valid  out  1  prefetch issue request
- io_mshr_req_ready  in  1  MSHR accepts
- io_mshr_req_bits_addr  out  40  block-aligned address (bits 5:0 zero)
- io_mshr_req_bits_cmd  out  5  command of head entry
- io_drop_count  out  16  saturating count of discarded requests

## Operation
- Block address = addr[39:6]. FIFO entry: {blk[33:0], cmd[4:0]}; filter entry: {valid, blk}.
- Accept (fire) when io_pf_valid & io_pf_ready. io_pf_ready = ~full & ~io_flush.
- On accept, request is dropped (not enqueued, drop_count+1) if:
  - cmd[4:1] != 4'h1, or
  - blk matches any valid FIFO entry (including the head being dequeued this cycle), or
  - blk matches any valid filter entry.
- Otherwise enqueued at tail. A dropped request still completes the handshake.
- Duplicate in FIFO with different cmd: still dropped; queued cmd unchanged.
- io_mshr_req_valid = ~empty & ~io_demand_busy; addr = {head.blk, 6'h0}; cmd = head.cmd. Valid may deassert without fire while demand_busy is high; head contents stable until fire.
- Issue fire (valid & io_mshr_req_ready): pop head, write head.blk into filter at round-robin pointer (valid=1), advance pointer mod FILTER_ENTRIES (overwrites oldest).
- io_flush: next edge clears FIFO (count=0, pointers 0), all filter valids, filter pointer; no accept or issue that cycle (mshr_req_valid forced 0). drop_count not cleared.
- drop_count saturates at 16'hFFFF.

## Timing
- Reset (async): count=0, head/tail=0, filter valids=0, filter pointer=0, drop_count=0; hence io_pf_ready=1, io_mshr_req_valid=0, addr/cmd outputs 0 (storage reset to 0).
- Latency: accepted request visible on io_mshr_req_valid the following cycle at earliest; no combinational bypass from io_pf_* to io_mshr_req_*.
- Simultaneous enqueue+issue: allowed when not full; count unchanged. When full, ready=0 even if head issues that cycle (no full-bypass).
- Filter write on issue visible to dedup from next cycle; same-cycle match covered by FIFO-head compare.
- Pointer wrap: head/tail mod ENTRIES, full distinguished by count (log2(ENTRIES)+1 bits).
- Reset asserted mid-operation clears immediately regardless of handshakes in flight.

## Test plan
- Reset then push addr 40'h80001000 cmd 5'h2, mshr_ready=1 -> next cycle mshr_req_valid=1, addr 40'h80001000, cmd 5'h2; pops, count 0.
- Push 40'h80001010 then 40'h80001038 (same block), mshr_ready=0 -> second dropped, drop_count=1, one entry queued.
- mshr_ready=0, push 5 distinct blocks -> ready drops after 4th; 5th stalls; one issue -> ready=1 next cycle; order preserved across pointer wrap.
- Issue block 0x80002000, then re-push it -> dropped by filter; after 8 further distinct issues, re-push -> enqueued (evicted).
- Head pending, io_demand_busy=1 with mshr_ready=1 -> mshr_req_valid=0, no pop; deassert -> issue.
- 3 entries queued, pulse io_flush -> ready=0 that cycle, then empty, filter cleared, drop_count retained; cmd 5'h0 push -> dropped; async reset mid-queue -> all outputs to reset values without clock edge.
